or1200_if_fetchq: RTL and testbench

//  Instruction-fetch queue between the instruction bus and decode, fed with the

---
 rtl/or1200_fetch_pkg.sv | 34 +++
 rtl/or1200_fetch_fifo.sv | 72 +++++++
 rtl/or1200_if_fetchq.sv | 118 +++++++++++
 tb/tb_or1200_if_fetchq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/or1200_fetch_pkg.sv
// Shared types for the instruction-fetch queue.
//  OR1200_NOP_INSN  l.nop encoding, the default head instruction
//  fetchq_state_e   fetch-queue control states
//  fetchq_entry_t   one queued fetch: word-aligned PC, instruction, bus error
package or1200_fetch_pkg;

  localparam logic [31:0] OR1200_NOP_INSN = 32'h1500_0000;

  typedef enum logic [1:0] {
    FQ_RUN     = 2'd0,
    FQ_DISCARD = 2'd1,
    FQ_ERRHOLD = 2'd2
  } fetchq_state_e;

  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] insn;
    logic        err;
  } fetchq_entry_t;

  // Build a queue entry from a bus response; a faulting fetch carries a nop so
  // decode never sees stale bus data.
  function automatic fetchq_entry_t fetchq_mk_entry(input logic [31:0] adr,
                                                    input logic [31:0] dat,
                                                    input logic        err,
                                                    input logic [31:0] nop);
    fetchq_entry_t e;
    e.pc   = adr[31:2];
    e.insn = err ? nop : dat;
    e.err  = err;
    return e;
  endfunction

endpackage

// File: rtl/or1200_fetch_fifo.sv
// Synchronous FIFO of fetchq_entry_t with simultaneous push/pop.
//  clk, rst       clock, asynchronous active-low reset
//  clr            empty the FIFO (wins over push/pop)
//  push, wdata    write one entry (ignored when full unless popping)
//  pop            remove the head entry (ignored when empty)
//  cnt            current occupancy
//  cnt_nxt        occupancy after this edge
//  head_nxt       head entry after this edge (meaningful when cnt_nxt != 0)
// The look-ahead outputs let the parent register its head outputs without a
// bypass path from the bus to decode.
module or1200_fetch_fifo
  import or1200_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  fetchq_entry_t wdata,
  input  logic          pop,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_nxt,
  output fetchq_entry_t head_nxt
);

  fetchq_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] rd_after;
  logic [CW-1:0] remain;
  logic          do_push, do_pop;

  assign do_pop  = pop & (cnt != '0) & ~clr;
  assign do_push = push & ((cnt != CW'(DEPTH)) | do_pop) & ~clr;

  // State once this cycle's pop has happened; a push into what is then an
  // empty FIFO becomes the new head directly.
  assign rd_after = rd_ptr + AW'(do_pop);
  assign remain   = cnt - CW'(do_pop);
  assign head_nxt = (remain == '0) ? wdata : mem[rd_after];

  always_comb begin
    cnt_nxt = cnt;
    if (clr) cnt_nxt = '0;
    else     cnt_nxt = cnt + CW'(do_push) - CW'(do_pop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/or1200_if_fetchq.sv
// Instruction-fetch queue between the instruction bus and decode.
//  clk, rst         clock, asynchronous active-low reset
//  icpu_adr_i/dat_i returned address and instruction word
//  icpu_ack_i/err_i word valid / bus error for icpu_adr_i
//  icpu_busy_i      a request is still outstanding
//  flush_i          pipeline flush (branch, exception, debug)
//  id_freeze_i      decode not accepting this cycle
//  if_insn_o/pc_o   registered head instruction and PC (nop / 0 when empty)
//  if_valid_o       head entry valid
//  if_err_o         head entry carries a bus error
//  if_stall_o       queue full, genpc must hold its pc
//  genpc_refetch_o  one-cycle pulse: a word was dropped on overflow
// Control: RUN accepts words. DISCARD eats the one response still in flight
// when a flush hit a busy bus. ERRHOLD ignores everything after a bus error
// until the flush that the exception will raise.
module or1200_if_fetchq
  import or1200_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INSN = OR1200_NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] icpu_adr_i,
  input  logic [31:0] icpu_dat_i,
  input  logic        icpu_ack_i,
  input  logic        icpu_err_i,
  input  logic        icpu_busy_i,
  input  logic        flush_i,
  input  logic        id_freeze_i,
  output logic [31:0] if_insn_o,
  output logic [31:0] if_pc_o,
  output logic        if_valid_o,
  output logic        if_err_o,
  output logic        if_stall_o,
  output logic        genpc_refetch_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetchq_state_e state_q, state_d;
  fetchq_entry_t wdata, head_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          word, full, pop, push, drop_ovf;

  assign word  = icpu_ack_i | icpu_err_i;
  assign full  = (cnt == CW'(DEPTH));
  assign pop   = if_valid_o & ~id_freeze_i & ~flush_i;
  assign wdata = fetchq_mk_entry(icpu_adr_i, icpu_dat_i, icpu_err_i, NOP_INSN);

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    drop_ovf = 1'b0;
    case (state_q)
      FQ_RUN: begin
        if (flush_i) begin
          if (icpu_busy_i) state_d = FQ_DISCARD;
        end else if (word) begin
          // Full queue only takes a word if decode frees a slot this cycle.
          if (full && !pop) begin
            drop_ovf = 1'b1;
          end else begin
            push = 1'b1;
            if (icpu_err_i) state_d = FQ_ERRHOLD;
          end
        end
      end
      FQ_DISCARD: begin
        if (!flush_i && word) state_d = FQ_RUN;
      end
      FQ_ERRHOLD: begin
        if (flush_i) state_d = icpu_busy_i ? FQ_DISCARD : FQ_RUN;
      end
      default: state_d = FQ_RUN;
    endcase
  end

  or1200_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush_i),
    .push     (push),
    .wdata    (wdata),
    .pop      (pop),
    .cnt      (cnt),
    .cnt_nxt  (cnt_nxt),
    .head_nxt (head_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= FQ_RUN;
      if_valid_o      <= 1'b0;
      if_insn_o       <= NOP_INSN;
      if_pc_o         <= '0;
      if_err_o        <= 1'b0;
      if_stall_o      <= 1'b0;
      genpc_refetch_o <= 1'b0;
    end else begin
      state_q         <= state_d;
      genpc_refetch_o <= drop_ovf;
      if_stall_o      <= (cnt_nxt == CW'(DEPTH));
      if (cnt_nxt != '0) begin
        if_valid_o <= 1'b1;
        if_insn_o  <= head_nxt.insn;
        if_pc_o    <= {head_nxt.pc, 2'b00};
        if_err_o   <= head_nxt.err;
      end else begin
        if_valid_o <= 1'b0;
        if_insn_o  <= NOP_INSN;
        if_pc_o    <= '0;
        if_err_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_or1200_if_fetchq.sv
module tb_or1200_if_fetchq;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h1500_0000;

  logic        clk, rst;
  logic [31:0] icpu_adr_i, icpu_dat_i;
  logic        icpu_ack_i, icpu_err_i, icpu_busy_i, flush_i, id_freeze_i;
  logic [31:0] if_insn_o, if_pc_o;
  logic        if_valid_o, if_err_o, if_stall_o, genpc_refetch_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  or1200_if_fetchq #(.DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .icpu_adr_i      (icpu_adr_i),
    .icpu_dat_i      (icpu_dat_i),
    .icpu_ack_i      (icpu_ack_i),
    .icpu_err_i      (icpu_err_i),
    .icpu_busy_i     (icpu_busy_i),
    .flush_i         (flush_i),
    .id_freeze_i     (id_freeze_i),
    .if_insn_o       (if_insn_o),
    .if_pc_o         (if_pc_o),
    .if_valid_o      (if_valid_o),
    .if_err_o        (if_err_o),
    .if_stall_o      (if_stall_o),
    .genpc_refetch_o (genpc_refetch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check the head against the scoreboard,
  // update the scoreboard with what the queue must do, clock, check refetch.
  // acc = this word must be queued; ovf = it must be dropped with a refetch.
  task automatic step(input string tag, input logic ack, input logic err,
                      input logic [31:0] adr, input logic [31:0] dat,
                      input logic busy, input logic fl, input logic frz,
                      input logic acc, input logic ovf);
    bit   popping;
    exp_t e;
    icpu_ack_i  = ack;
    icpu_err_i  = err;
    icpu_adr_i  = adr;
    icpu_dat_i  = dat;
    icpu_busy_i = busy;
    flush_i     = fl;
    id_freeze_i = frz;
    chk1({tag, ".valid"}, if_valid_o, sb.size() != 0);
    chk1({tag, ".stall"}, if_stall_o, sb.size() == DEPTH);
    if (sb.size() != 0) begin
      chk32({tag, ".pc"},   if_pc_o,   sb[0].pc);
      chk32({tag, ".insn"}, if_insn_o, sb[0].insn);
      chk1 ({tag, ".err"},  if_err_o,  sb[0].err);
    end else begin
      chk32({tag, ".insn"}, if_insn_o, NOP);
      chk1 ({tag, ".err"},  if_err_o,  1'b0);
    end
    popping = (sb.size() != 0) && !frz && !fl;
    if (fl) sb.delete();
    else begin
      if (popping) void'(sb.pop_front());
      if (acc) begin
        e.pc   = {adr[31:2], 2'b00};
        e.insn = err ? NOP : dat;
        e.err  = err;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk1({tag, ".refetch"}, genpc_refetch_o, ovf);
  endtask

  task automatic idle(input string tag, input logic frz);
    step(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, frz, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    icpu_adr_i = '0; icpu_dat_i = '0; icpu_ack_i = 1'b0; icpu_err_i = 1'b0;
    icpu_busy_i = 1'b0; flush_i = 1'b0; id_freeze_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1 ("rst.valid",   if_valid_o, 1'b0);
    chk32("rst.insn",    if_insn_o, NOP);
    chk32("rst.pc",      if_pc_o, 32'h0);
    chk1 ("rst.err",     if_err_o, 1'b0);
    chk1 ("rst.stall",   if_stall_o, 1'b0);
    chk1 ("rst.refetch", genpc_refetch_o, 1'b0);
    rst = 1'b1;

    // 1: single word, no freeze
    step("t1.ack", 1, 0, 32'h100, 32'hA800_0001, 0, 0, 0, 1, 0);
    idle("t1.head", 0);
    idle("t1.empty", 0);

    // 2: fill under freeze, overflow drop, then drain
    step("t2.a200", 1, 0, 32'h200, 32'h1111_0000, 1, 0, 1, 1, 0);
    step("t2.a204", 1, 0, 32'h204, 32'h1111_0004, 1, 0, 1, 1, 0);
    step("t2.a208", 1, 0, 32'h208, 32'h1111_0008, 0, 0, 1, 0, 1);
    idle("t2.hold", 1);
    idle("t2.pop0", 0);
    idle("t2.pop1", 0);
    idle("t2.empty", 0);

    // 3: flush with busy bus; in-flight word dropped, next accepted
    step("t3.a2f0",  1, 0, 32'h2F0, 32'h2222_0000, 1, 0, 1, 1, 0);
    step("t3.flush", 1, 0, 32'h2F4, 32'h2222_0004, 1, 1, 1, 0, 0);
    step("t3.a300",  1, 0, 32'h300, 32'h3333_0000, 1, 0, 0, 0, 0);
    step("t3.a400",  1, 0, 32'h400, 32'h4444_0000, 0, 0, 0, 1, 0);
    idle("t3.head", 0);
    idle("t3.empty", 0);

    // 4: bus error, hold until flush, then resume
    step("t4.e500",  0, 1, 32'h500, 32'hDEAD_BEEF, 0, 0, 0, 1, 0);
    step("t4.a504",  1, 0, 32'h504, 32'h5555_0004, 0, 0, 0, 0, 0);
    step("t4.a508",  1, 0, 32'h508, 32'h5555_0008, 0, 0, 0, 0, 0);
    step("t4.flush", 0, 0, 32'h0,   32'h0,         0, 1, 0, 0, 0);
    step("t4.a100",  1, 0, 32'h100, 32'h6666_0000, 0, 0, 0, 1, 0);
    idle("t4.head", 0);
    idle("t4.empty", 0);

    // 5: full queue, push and pop in the same cycle
    step("t5.a700", 1, 0, 32'h700, 32'h7777_0000, 1, 0, 1, 1, 0);
    step("t5.a704", 1, 0, 32'h704, 32'h7777_0004, 1, 0, 1, 1, 0);
    step("t5.a708", 1, 0, 32'h708, 32'h7777_0008, 1, 0, 0, 1, 0);
    step("t5.a70c", 1, 0, 32'h70C, 32'h7777_000C, 0, 0, 0, 1, 0);
    idle("t5.pop0", 0);
    idle("t5.pop1", 0);
    idle("t5.empty", 0);

    // 6: async reset with two entries queued
    step("t6.a800", 1, 0, 32'h800, 32'h8888_0000, 1, 0, 1, 1, 0);
    step("t6.a804", 1, 0, 32'h804, 32'h8888_0004, 1, 0, 1, 1, 0);
    chk1("t6.full", if_stall_o, 1'b1);
    icpu_ack_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk1("t6.rst.valid", if_valid_o, 1'b0);
    chk1("t6.rst.stall", if_stall_o, 1'b0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    // first word after reset is accepted normally
    step("t6.a900", 1, 0, 32'h900, 32'h9999_0000, 1, 0, 0, 1, 0);
    idle("t6.head", 0);
    idle("t6.empty", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
